// File: rtl/period_abs_sum_accum.sv
// period_abs_sum_accum
//   Streaming per-period absolute-value accumulator for the detection path.
//   Each beat carries LANES signed samples. Every lane is converted to |x|, the
//   lanes are reduced by a registered adder tree, and the per-beat sums are
//   accumulated until a beat flagged with InLast closes the period. The
//   accumulator then loads one result (sum, beat count, overflow) into the
//   output register for the threshold logic.
//
// Handshake (valid/ready, both ports):
//   A transfer happens on a rising Clk edge where valid && ready are both 1.
//   A producer holds valid and its payload until that edge. Ready may depend
//   combinationally on the consumer's OutReady. The whole pipeline advances
//   together (adv) whenever the output register is empty or being drained.
//   So InReady == adv, and no beat is dropped or repeated under back-pressure.
//
// Ports
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   InValid/InReady     input beat handshake
//   InData              LANES x SAMPLE_W two's complement, lane i at [SAMPLE_W*i +: SAMPLE_W]
//   InLast              beat closes the current period
//   OutValid/OutReady   result handshake
//   AbsSum              saturating sum of |x| over the period
//   BeatCount           beats in the period, saturating at all-ones
//   Overflow            AbsSum saturated during this period
//   MaxAbs              largest |x| in the period (only with PERIOD_ABS_SUM_MAXABS_EN)
//   dbg_state           accumulator FSM state (1 = ACCUM, inside a period)
//
// Optional feature macro: PERIOD_ABS_SUM_MAXABS_EN adds the MaxAbs output.
// The MaxAbs path uses the same pipeline as the sum.

module period_abs_sum_accum #(
    parameter int LANES    = 16,
    parameter int SAMPLE_W = 8,
    parameter int SUM_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [LANES*SAMPLE_W-1:0] InData,
    input  logic                      InLast,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [SUM_W-1:0]          AbsSum,
    output logic [CNT_W-1:0]          BeatCount,
    output logic                      Overflow,
`ifdef PERIOD_ABS_SUM_MAXABS_EN
    output logic [SAMPLE_W-1:0]       MaxAbs,
`endif
    output logic                      dbg_state
);

    localparam int LEVELS = $clog2(LANES);
    localparam int TREE_W = SAMPLE_W + LEVELS;

    // Global advance: every stage moves only when the output register can take a new result.
    logic adv;
    assign adv     = !(OutValid && !OutReady);
    assign InReady = adv;

    // The unsigned result in SAMPLE_W bits covers the most-negative input (-2^(W-1) -> 2^(W-1)).
    function automatic logic [SAMPLE_W-1:0] abs_s(input logic [SAMPLE_W-1:0] x);
        return x[SAMPLE_W-1] ? -x : x;
    endfunction

    // Level 0 holds the registered abs values. Level l holds LANES>>l partial sums,
    // and each level is one bit wider than the one before it.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = LANES >> l;
        localparam int W = SAMPLE_W + l;

        logic         v;
        logic         lst;
        logic [W-1:0] s [N];
`ifdef PERIOD_ABS_SUM_MAXABS_EN
        logic [SAMPLE_W-1:0] m [N];
`endif

        if (l == 0) begin : g_abs
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    v   <= 1'b0;
                    lst <= 1'b0;
                    for (int i = 0; i < N; i++) s[i] <= '0;
                end else if (adv) begin
                    v   <= InValid;
                    lst <= InValid && InLast;
                    for (int i = 0; i < N; i++) s[i] <= abs_s(InData[SAMPLE_W*i +: SAMPLE_W]);
                end
            end
`ifdef PERIOD_ABS_SUM_MAXABS_EN
            for (genvar i = 0; i < N; i++) begin : g_m0
                assign m[i] = s[i];
            end
`endif
        end else begin : g_add
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    v   <= 1'b0;
                    lst <= 1'b0;
                    for (int i = 0; i < N; i++) begin
                        s[i] <= '0;
`ifdef PERIOD_ABS_SUM_MAXABS_EN
                        m[i] <= '0;
`endif
                    end
                end else if (adv) begin
                    v   <= g_lvl[l-1].v;
                    lst <= g_lvl[l-1].lst;
                    for (int i = 0; i < N; i++) begin
                        s[i] <= {1'b0, g_lvl[l-1].s[2*i]} + {1'b0, g_lvl[l-1].s[2*i+1]};
`ifdef PERIOD_ABS_SUM_MAXABS_EN
                        m[i] <= (g_lvl[l-1].m[2*i] > g_lvl[l-1].m[2*i+1]) ?
                                g_lvl[l-1].m[2*i] : g_lvl[l-1].m[2*i+1];
`endif
                    end
                end
            end
        end
    end

    logic              t_valid;
    logic              t_last;
    logic [TREE_W-1:0] t_sum;
    assign t_valid = g_lvl[LEVELS].v;
    assign t_last  = g_lvl[LEVELS].lst;
    assign t_sum   = g_lvl[LEVELS].s[0];
`ifdef PERIOD_ABS_SUM_MAXABS_EN
    logic [SAMPLE_W-1:0] t_max;
    assign t_max = g_lvl[LEVELS].m[0];
`endif

    // Accumulator FSM
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
    state_t state;

    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [SUM_W-1:0] base_acc;
    logic             base_ovf;
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W-1:0] nxt_acc;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_ovf;
`ifdef PERIOD_ABS_SUM_MAXABS_EN
    logic [SAMPLE_W-1:0] acc_max;
    logic [SAMPLE_W-1:0] nxt_max;
`endif

    // In IDLE the beat starts a fresh period, so the running state is ignored.
    always_comb begin
        base_acc = (state == ACCUM) ? acc : '0;
        base_ovf = (state == ACCUM) ? ovf : 1'b0;
        sum_ext  = {1'b0, base_acc} + (SUM_W+1)'(t_sum);
        nxt_acc  = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        nxt_ovf  = base_ovf | sum_ext[SUM_W];
        if (state == IDLE)
            nxt_cnt = CNT_W'(1);
        else if (cnt == '1)
            nxt_cnt = cnt;
        else
            nxt_cnt = cnt + CNT_W'(1);
`ifdef PERIOD_ABS_SUM_MAXABS_EN
        nxt_max = ((state == ACCUM) && (acc_max > t_max)) ? acc_max : t_max;
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            OutValid  <= 1'b0;
            AbsSum    <= '0;
            BeatCount <= '0;
            Overflow  <= 1'b0;
`ifdef PERIOD_ABS_SUM_MAXABS_EN
            acc_max   <= '0;
            MaxAbs    <= '0;
`endif
        end else if (adv) begin
            // adv implies the output register is empty or draining this edge.
            OutValid <= t_valid && t_last;
            if (t_valid) begin
                if (t_last) begin
                    AbsSum    <= nxt_acc;
                    BeatCount <= nxt_cnt;
                    Overflow  <= nxt_ovf;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    state     <= IDLE;
`ifdef PERIOD_ABS_SUM_MAXABS_EN
                    MaxAbs    <= nxt_max;
                    acc_max   <= '0;
`endif
                end else begin
                    acc       <= nxt_acc;
                    cnt       <= nxt_cnt;
                    ovf       <= nxt_ovf;
                    state     <= ACCUM;
`ifdef PERIOD_ABS_SUM_MAXABS_EN
                    acc_max   <= nxt_max;
`endif
                end
            end
        end
    end

    assign dbg_state = (state == ACCUM);

endmodule
